// File: rtl/scan_test_controller_if.sv
// Pattern/response handshakes plus the scan-chain pins of the scan sequencer.
// The controller uses the slave side; the harness that owns the chain uses master.
interface scan_test_controller_if #(
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 16
);
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [CHAIN_LEN-1:0] resp_data;
  logic                 scan_en;
  logic                 chain_ce;
  logic                 scan_si;
  logic                 scan_so;
  logic                 capture;
  logic                 busy;
  logic [CNT_W-1:0]     pat_cnt;

  modport slave (
    input  pat_valid, pat_data, resp_ready, scan_so,
    output pat_ready, resp_valid, resp_data, scan_en, chain_ce, scan_si,
           capture, busy, pat_cnt
  );

  modport master (
    output pat_valid, pat_data, resp_ready, scan_so,
    input  pat_ready, resp_valid, resp_data, scan_en, chain_ce, scan_si,
           capture, busy, pat_cnt
  );
endinterface

// File: rtl/scan_test_controller.sv
// Scan sequencer: shifts a pattern in MSB-first, fires one capture cycle and
// shifts the response out, overlapping the unload with the next pattern's load.
module scan_test_controller #(
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  scan_test_controller_if.slave   bus
);
  localparam int N  = CHAIN_LEN;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CAPT, S_UNLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [N-1:0]     r_pat, w_pat_nxt;
  logic [N-1:0]     r_resp_sh, w_resp_sh_nxt;
  logic [N-1:0]     r_resp_data, w_resp_data_nxt;
  logic             r_has_pat, w_has_pat_nxt;
  logic             r_resp_valid, w_resp_valid_nxt;
  logic [CNT_W-1:0] r_pat_cnt, w_pat_cnt_nxt;
  logic             r_pat_ready, r_scan_en, r_chain_ce, r_capture, r_busy;
  logic             w_accept, w_shift, w_last, w_hold_nxt;

  assign w_accept = bus.pat_valid && r_pat_ready;
  assign w_shift  = r_scan_en && r_chain_ce;
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_pat_nxt        = r_pat;
    w_resp_sh_nxt    = r_resp_sh;
    w_resp_data_nxt  = r_resp_data;
    w_has_pat_nxt    = r_has_pat;
    w_resp_valid_nxt = r_resp_valid && !bus.resp_ready;
    w_pat_cnt_nxt    = r_pat_cnt;
    // The pattern register drains to zero, so scan_si idles low for free.
    if (w_shift) w_pat_nxt = {r_pat[N-2:0], 1'b0};
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = '0;
        w_pat_nxt   = bus.pat_data;
      end
      S_LOAD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_resp_valid ? S_WAIT : S_CAPT;
        end
      end
      S_WAIT: if (!r_resp_valid) w_state_nxt = S_CAPT;
      S_CAPT: begin
        w_state_nxt   = S_UNLD;
        w_cnt_nxt     = '0;
        w_has_pat_nxt = w_accept;
        if (w_accept) w_pat_nxt = bus.pat_data;
      end
      S_UNLD: if (w_shift) begin
        w_resp_sh_nxt = {r_resp_sh[N-2:0], bus.scan_so};
        w_cnt_nxt     = r_cnt + 1'b1;
        if (w_last) begin
          w_cnt_nxt        = '0;
          w_resp_data_nxt  = w_resp_sh_nxt;
          w_resp_valid_nxt = 1'b1;
          w_pat_cnt_nxt    = r_pat_cnt + 1'b1;
          w_state_nxt      = r_has_pat ? S_CAPT : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Freeze the final unload shift while an older response is still pending,
  // so a back-to-back capture can never overwrite undelivered data.
  assign w_hold_nxt = (w_state_nxt == S_UNLD) && (w_cnt_nxt == LAST) && w_resp_valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_pat        <= '0;
      r_resp_sh    <= '0;
      r_resp_data  <= '0;
      r_has_pat    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_pat_cnt    <= '0;
      r_pat_ready  <= 1'b1;
      r_scan_en    <= 1'b0;
      r_chain_ce   <= 1'b0;
      r_capture    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pat        <= w_pat_nxt;
      r_resp_sh    <= w_resp_sh_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_has_pat    <= w_has_pat_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_pat_cnt    <= w_pat_cnt_nxt;
      r_pat_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CAPT);
      r_scan_en    <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_UNLD);
      r_chain_ce   <= ((w_state_nxt == S_LOAD) || (w_state_nxt == S_CAPT) ||
                       (w_state_nxt == S_UNLD)) && !w_hold_nxt;
      r_capture    <= (w_state_nxt == S_CAPT);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.pat_ready  = r_pat_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.scan_en    = r_scan_en;
  assign bus.chain_ce   = r_chain_ce;
  assign bus.scan_si    = r_pat[N-1];
  assign bus.capture    = r_capture;
  assign bus.busy       = r_busy;
  assign bus.pat_cnt    = r_pat_cnt;
endmodule

// File: tb/tb_scan_test_controller.sv
// Bench: 4-flop scan chain plant (hold or 4-bit counter core) around the
// controller, a response scoreboard checked every cycle, and directed scenarios.
module tb_scan_test_controller;
  localparam int N  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_test_controller_if #(.CHAIN_LEN(N), .CNT_W(CW)) bus();
  scan_test_controller #(.CHAIN_LEN(N), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  int mode = 0; // 0: core holds its value at capture, 1: counter core counts

  function automatic logic [N-1:0] func(input logic [N-1:0] v, input int m);
    return (m == 1) ? v + 1'b1 : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Chain plant: flop k shifts from flop k-1, flop 0 from Si.
  logic [N-1:0] q = '0;
  logic co;
  always @(posedge clk)
    if (bus.chain_ce) q <= bus.scan_en ? {q[N-2:0], bus.scan_si} : func(q, mode);
  assign bus.scan_so = q[N-1];
  assign co = (mode == 1) && (&q);

  // Scoreboard: each accepted pattern must come back as the core's capture of it.
  logic [N-1:0] exp_q[$];
  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
    if (rst) exp_q.delete();
    else if (bus.pat_valid && bus.pat_ready) exp_q.push_back(func(bus.pat_data, mode));
  end

  logic held = 1'b0;
  logic chk_en = 1'b0;
  logic [N-1:0] prev_data = '0;
  int model_cnt = 0;
  int resp_t[$];
  int cnt_log[$];
  logic si_en = 1'b0;
  logic [15:0] si_bits = '0;
  int si_n = 0;

  always @(negedge clk) begin
    if (rst_q) begin
      held = 1'b0;
      model_cnt = 0;
    end else if (chk_en) begin
      if (bus.resp_valid && !held) begin
        model_cnt++;
        resp_t.push_back(cyc);
        cnt_log.push_back(int'(bus.pat_cnt));
        if (exp_q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
        else chk("resp_data", bus.resp_data, exp_q.pop_front());
      end else if (bus.resp_valid) chk("resp_stable", bus.resp_data, prev_data);
      chk("pat_cnt", bus.pat_cnt, model_cnt % (1 << CW));
      chk("pat_ready_rule", bus.pat_ready, !bus.busy || bus.capture);
      chk("scan_en_rule", bus.scan_en, bus.busy && !bus.capture);
      if (!bus.busy) chk("idle_ce_si", {bus.chain_ce, bus.scan_si}, 2'b00);
      if (bus.capture) chk("capture_ce", bus.chain_ce, 1'b1);
      if (si_en && bus.scan_en && bus.chain_ce) begin
        si_bits = {si_bits[14:0], bus.scan_si};
        si_n++;
      end
      held = bus.resp_valid && !bus.resp_ready;
      prev_data = bus.resp_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.pat_data  = d;
    bus.pat_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.pat_ready;
      step();
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    bus.pat_valid = 1'b0;
  endtask

  task automatic wait_resp(output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (bus.resp_valid) ok = 1'b1;
    end
    t = cyc;
    if (!ok) chk("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_cap();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (bus.capture) ok = 1'b1;
    end
    if (!ok) chk("capture_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_nresp(input int n);
    for (int k = 0; k < 300 && resp_t.size() < n; k++) @(negedge clk);
    chk("resp_count", resp_t.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, ce;
    int exp_cnt[5];
    exp_cnt = '{1, 2, 3, 0, 1};
    bus.pat_valid  = 1'b0;
    bus.pat_data   = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_pat_ready", bus.pat_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_scan_en", bus.scan_en, 1'b0);
    chk("rst_chain_ce", bus.chain_ce, 1'b0);
    chk("rst_scan_si", bus.scan_si, 1'b0);
    chk("rst_capture", bus.capture, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_data", bus.resp_data, 4'h0);
    chk("rst_pat_cnt", bus.pat_cnt, 2'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // T1: latency and identity through a holding core
    mode = 0;
    send(4'b1010);
    ce = cyc;
    wait_resp(t);
    chk("t1_latency", t - ce, 9);
    chk("t1_data", bus.resp_data, 4'b1010);
    chk("t1_cnt", bus.pat_cnt, 2'd1);

    // T2: counter core increments at capture; carry seen on all-ones
    mode = 1;
    step();
    send(4'b0111);
    wait_cap();
    chk("t2a_chain", q, 4'b0111);
    chk("t2a_co", co, 1'b0);
    wait_resp(t);
    chk("t2a_data", bus.resp_data, 4'b1000);
    step();
    send(4'b1111);
    wait_cap();
    chk("t2b_co", co, 1'b1);
    wait_resp(t);
    chk("t2b_data", bus.resp_data, 4'b0000);

    // T3: continuous patterns, N+1 spacing, MSB-first stream on scan_si
    mode = 0;
    step();
    resp_t.delete();
    si_bits = '0;
    si_n = 0;
    si_en = 1'b1;
    send(4'b1100);
    send(4'b0110);
    send(4'b1001);
    wait_nresp(3);
    si_en = 1'b0;
    if (resp_t.size() == 3) begin
      chk("t3_gap01", resp_t[1] - resp_t[0], 5);
      chk("t3_gap12", resp_t[2] - resp_t[1], 5);
    end
    chk("t3_si_stream", si_bits, 16'hC690);
    chk("t3_si_count", si_n, 16);

    // T4: back-pressure parks the second pattern in WAIT
    step();
    bus.resp_ready = 1'b0;
    send(4'b0101);
    wait_resp(t);
    step();
    send(4'b0011);
    repeat (20) step();
    chk("t4_busy", bus.busy, 1'b1);
    chk("t4_scan_en", bus.scan_en, 1'b1);
    chk("t4_chain_ce", bus.chain_ce, 1'b0);
    chk("t4_capture", bus.capture, 1'b0);
    chk("t4_resp_valid", bus.resp_valid, 1'b1);
    chk("t4_resp_data", bus.resp_data, 4'b0101);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk("t4_cap_h1", bus.capture, 1'b0);
    chk("t4_valid_h1", bus.resp_valid, 1'b0);
    @(negedge clk);
    chk("t4_cap_h2", bus.capture, 1'b1);
    bus.resp_ready = 1'b1;
    wait_resp(t);
    chk("t4_data2", bus.resp_data, 4'b0011);

    // T5: reset during the second unload cycle
    step();
    send(4'b0110);
    wait_resp(t);
    step();
    send(4'b1110);
    repeat (6) step();
    chk("t5_pre_busy", bus.busy, 1'b1);
    chk("t5_pre_capture", bus.capture, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_pat_ready", bus.pat_ready, 1'b1);
    chk("t5_resp_valid", bus.resp_valid, 1'b0);
    chk("t5_pat_cnt", bus.pat_cnt, 2'd0);
    step();
    send(4'b0001);
    ce = cyc;
    wait_resp(t);
    chk("t5_latency", t - ce, 9);
    chk("t5_data", bus.resp_data, 4'b0001);
    chk("t5_cnt", bus.pat_cnt, 2'd1);

    // T6: pattern counter wraps at 2 bits
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_log.delete();
    resp_t.delete();
    send(4'b0001);
    send(4'b0010);
    send(4'b0100);
    send(4'b1000);
    send(4'b1111);
    wait_nresp(5);
    for (int i = 0; i < 5; i++)
      if (i < cnt_log.size()) chk($sformatf("t6_cnt%0d", i), cnt_log[i], exp_cnt[i]);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
